// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the instruction-fetch front end.
//   FetchEntry_t     - one prefetch buffer entry {pc, inst, err} at the default
//                      32-bit address/data configuration
//   FetchState_t     - fetch bus FSM states
//   DEFAULT_RESET_PC - fetch address after reset
//   is_word_aligned  - helper: true when the low two address bits are zero
// -----------------------------------------------------------------------------
package cpu_defs;

    localparam int CPU_ADDR_WIDTH = 32;
    localparam int CPU_DATA_WIDTH = 32;

    localparam logic [CPU_ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic [CPU_ADDR_WIDTH-1:0] pc;
        logic [CPU_DATA_WIDTH-1:0] inst;
        logic                      err;
    } FetchEntry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2,
        HALT    = 2'd3
    } FetchState_t;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous first-word-fall-through FIFO holding prefetched instructions.
// The head entry is presented combinationally from storage.
//   clk, rst    - clock, synchronous active-high reset (empties the FIFO)
//   flush       - discard all entries at the next edge; overrides push/pop
//   push        - write push_data at the tail
//   push_data   - entry to write
//   pop         - drop the head entry
//   head        - current head entry (meaningful only when !empty)
//   count       - number of stored entries, 0..DEPTH
//   empty, full - occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo
    import cpu_defs::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = FetchEntry_t,
    localparam int AW      = $clog2(DEPTH),
    localparam int PW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic [PW-1:0] count,
    output logic          empty,
    output logic          full
);

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit so that equal index bits with
    // different wrap bits mean full rather than empty.
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = (count == PW'(DEPTH));
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_data;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // The fetch FSM only requests when a slot is free, so a push into a
    // full FIFO indicates a design bug.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && full));
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end: owns the fetch PC, issues Wishbone classic
// reads with arbitrary wait states and buffers fetched words for ID.
//   clk, rst           - clock, synchronous active-high reset
//   ibus_cyc_o/stb_o   - Wishbone cycle/strobe (held until ack or err)
//   ibus_adr_o         - fetch address, stable while the strobe is up
//   ibus_sel_o         - byte selects, always all ones
//   ibus_ack_i/err_i   - transfer acknowledge / bus error
//   ibus_dat_i         - read data
//   jump, jump_to      - redirect: flush buffer, cancel in-flight fetch
//   id_valid, id_ready - handshake for the head prefetch entry
//   id_pc/inst/err     - head entry (zero when the buffer is empty)
// -----------------------------------------------------------------------------
module fetch_unit
    import cpu_defs::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ibus_cyc_o,
    output logic                    ibus_stb_o,
    output logic [ADDR_WIDTH-1:0]   ibus_adr_o,
    output logic [DATA_WIDTH/8-1:0] ibus_sel_o,
    input  logic                    ibus_ack_i,
    input  logic                    ibus_err_i,
    input  logic [DATA_WIDTH-1:0]   ibus_dat_i,
    input  logic                    jump,
    input  logic [ADDR_WIDTH-1:0]   jump_to,
    input  logic                    id_ready,
    output logic                    id_valid,
    output logic [ADDR_WIDTH-1:0]   id_pc,
    output logic [DATA_WIDTH-1:0]   id_inst,
    output logic                    id_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
        logic                  err;
    } entry_t;

    FetchState_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;

    logic                  fifo_push;
    entry_t                fifo_push_data;
    logic                  fifo_pop;
    entry_t                fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [ADDR_WIDTH-1:0] next_pc;

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (jump),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // The bus is owned for the whole of WAIT and DISCARD so a cancelled
    // transfer still completes cleanly on the Wishbone side.
    assign ibus_cyc_o = (state_q == WAIT) || (state_q == DISCARD);
    assign ibus_stb_o = ibus_cyc_o;
    assign ibus_adr_o = adr_q;
    assign ibus_sel_o = '1;

    assign id_valid = !fifo_empty;
    assign id_pc    = fifo_empty ? '0 : fifo_head.pc;
    assign id_inst  = fifo_empty ? '0 : fifo_head.inst;
    assign id_err   = fifo_empty ? '0 : fifo_head.err;

    // A redirect flushes the buffer, so the head must not also be popped.
    assign fifo_pop = id_valid && id_ready && !jump;

    assign next_pc = fetch_pc_q + ADDR_WIDTH'(4);

    // Next-state logic. A jump outranks every other event; in WAIT it either
    // drops a response arriving this cycle or leaves the transfer to DISCARD.
    // Bus address is held in its own register because fetch_pc may be
    // redirected while a cancelled transfer is still on the bus.
    always_comb begin
        state_d             = state_q;
        fetch_pc_d          = fetch_pc_q;
        adr_d               = adr_q;
        fifo_push           = 1'b0;
        fifo_push_data      = '0;
        fifo_push_data.pc   = adr_q;

        case (state_q)
            IDLE: begin
                if (jump) begin
                    fetch_pc_d = jump_to;
                end else if (!fifo_full) begin
                    if (!is_word_aligned(fetch_pc_q[1:0])) begin
                        fifo_push             = 1'b1;
                        fifo_push_data.pc     = fetch_pc_q;
                        fifo_push_data.err    = 1'b1;
                        state_d               = HALT;
                    end else begin
                        adr_d   = fetch_pc_q;
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                if (jump) begin
                    fetch_pc_d = jump_to;
                    state_d    = (ibus_ack_i || ibus_err_i) ? IDLE : DISCARD;
                end else if (ibus_ack_i) begin
                    fifo_push           = 1'b1;
                    fifo_push_data.inst = ibus_dat_i;
                    fetch_pc_d          = next_pc;
                    adr_d               = next_pc;
                    // Occupancy after this push (and any pop) stays below
                    // depth unless we are filling the last slot with no pop.
                    if (fifo_pop || (fifo_count != CNT_W'(FIFO_DEPTH - 1))) begin
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (ibus_err_i) begin
                    fifo_push          = 1'b1;
                    fifo_push_data.err = 1'b1;
                    state_d            = HALT;
                end
            end

            DISCARD: begin
                if (jump) begin
                    fetch_pc_d = jump_to;
                end
                if (ibus_ack_i || ibus_err_i) begin
                    state_d = IDLE;
                end
            end

            HALT: begin
                if (jump) begin
                    fetch_pc_d = jump_to;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            adr_q      <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            adr_q      <= adr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. The Wishbone slave returns ~address as data
// with a programmable number of wait states, an optional error address and
// a forced stray acknowledge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_cyc_o;
    logic        ibus_stb_o;
    logic [31:0] ibus_adr_o;
    logic [3:0]  ibus_sel_o;
    logic        ibus_ack_i;
    logic        ibus_err_i;
    logic [31:0] ibus_dat_i;
    logic        jump;
    logic [31:0] jump_to;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_err;

    int          tests = 0;
    int          fails = 0;
    int          wait_n = 0;
    int          ctr = 0;
    int          ack_count = 0;
    int          base;
    logic        err_en = 1'b0;
    logic [31:0] err_adr = 32'h0;
    logic        force_ack = 1'b0;
    logic        slave_hit;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .ibus_cyc_o (ibus_cyc_o),
        .ibus_stb_o (ibus_stb_o),
        .ibus_adr_o (ibus_adr_o),
        .ibus_sel_o (ibus_sel_o),
        .ibus_ack_i (ibus_ack_i),
        .ibus_err_i (ibus_err_i),
        .ibus_dat_i (ibus_dat_i),
        .jump       (jump),
        .jump_to    (jump_to),
        .id_ready   (id_ready),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_err     (id_err)
    );

    always #5 clk = ~clk;

    // Slave model: responds once the wait-state counter reaches wait_n.
    assign slave_hit  = ibus_cyc_o && ibus_stb_o && (ctr == wait_n);
    assign ibus_err_i = slave_hit && err_en && (ibus_adr_o == err_adr);
    assign ibus_ack_i = force_ack || (slave_hit && !ibus_err_i);
    assign ibus_dat_i = ~ibus_adr_o;

    always @(posedge clk) begin
        if (ibus_ack_i && ibus_cyc_o) begin
            ack_count <= ack_count + 1;
        end
        if (!ibus_stb_o || ibus_ack_i || ibus_err_i) begin
            ctr <= 0;
        end else begin
            ctr <= ctr + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic j, input logic [31:0] jt);
        rst      = r;
        id_ready = rdy;
        jump     = j;
        jump_to  = jt;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitValid(input int max_cycles, input string tag);
        for (int k = 0; k < max_cycles && !id_valid; k++) begin
            tick();
        end
        checkOutput(tag, 32'(id_valid), 32'd1);
    endtask

    task automatic doReset;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
    endtask

    initial begin
        // Reset state
        doReset();
        checkOutput("rst_cyc", 32'(ibus_cyc_o), 32'd0);
        checkOutput("rst_stb", 32'(ibus_stb_o), 32'd0);
        checkOutput("rst_valid", 32'(id_valid), 32'd0);
        checkOutput("rst_pc", id_pc, 32'h0);
        checkOutput("rst_inst", id_inst, 32'h0);
        checkOutput("rst_err", 32'(id_err), 32'd0);
        checkOutput("rst_sel", 32'(ibus_sel_o), 32'hF);

        // Zero-wait slave, ID always ready: one word per cycle
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("s1_stb", 32'(ibus_stb_o), 32'd1);
        checkOutput("s1_adr", ibus_adr_o, 32'hBFC0_0000);
        checkOutput("s1_valid0", 32'(id_valid), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("s1_valid", 32'(id_valid), 32'd1);
            checkOutput("s1_pc", id_pc, 32'hBFC0_0000 + 32'(4 * i));
            checkOutput("s1_inst", id_inst, ~(32'hBFC0_0000 + 32'(4 * i)));
            tick();
        end

        // ID stalled: buffer fills to four entries then bus goes quiet
        doReset();
        base = ack_count;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (5) tick();
        checkOutput("s2_cyc_full", 32'(ibus_cyc_o), 32'd0);
        checkOutput("s2_acks4", 32'(ack_count - base), 32'd4);
        checkOutput("s2_head", id_pc, 32'hBFC0_0000);
        repeat (2) tick();
        checkOutput("s2_cyc_idle", 32'(ibus_cyc_o), 32'd0);
        checkOutput("s2_acks4b", 32'(ack_count - base), 32'd4);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("s2_head_pop", id_pc, 32'hBFC0_0004);
        tick();
        checkOutput("s2_refetch_stb", 32'(ibus_stb_o), 32'd1);
        checkOutput("s2_refetch_adr", ibus_adr_o, 32'hBFC0_0010);
        tick();
        checkOutput("s2_cyc_after", 32'(ibus_cyc_o), 32'd0);
        tick();
        checkOutput("s2_acks5", 32'(ack_count - base), 32'd5);

        // Three wait states; jump during the first wait cycle
        doReset();
        wait_n = 3;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("s3_stb", 32'(ibus_stb_o), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h8000_1000);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("s3_disc_stb", 32'(ibus_stb_o), 32'd1);
        checkOutput("s3_disc_adr", ibus_adr_o, 32'hBFC0_0000);
        checkOutput("s3_disc_valid", 32'(id_valid), 32'd0);
        tick();
        tick();
        checkOutput("s3_hold_stb", 32'(ibus_stb_o), 32'd1);
        checkOutput("s3_hold_adr", ibus_adr_o, 32'hBFC0_0000);
        tick();
        checkOutput("s3_drop_cyc", 32'(ibus_cyc_o), 32'd0);
        checkOutput("s3_drop_valid", 32'(id_valid), 32'd0);
        tick();
        checkOutput("s3_new_stb", 32'(ibus_stb_o), 32'd1);
        checkOutput("s3_new_adr", ibus_adr_o, 32'h8000_1000);
        waitValid(10, "s3_wait_valid");
        checkOutput("s3_pc", id_pc, 32'h8000_1000);
        checkOutput("s3_inst", id_inst, 32'h7FFF_EFFF);

        // Jump coincides with ack while two entries are buffered
        wait_n = 0;
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        tick();
        checkOutput("s4_adr", ibus_adr_o, 32'hBFC0_0008);
        checkOutput("s4_head", id_pc, 32'hBFC0_0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h8000_2000);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("s4_flush_valid", 32'(id_valid), 32'd0);
        checkOutput("s4_flush_cyc", 32'(ibus_cyc_o), 32'd0);
        tick();
        checkOutput("s4_new_adr", ibus_adr_o, 32'h8000_2000);
        tick();
        checkOutput("s4_new_pc", id_pc, 32'h8000_2000);

        // Bus error halts fetch; misaligned redirect faults without bus access
        doReset();
        err_en  = 1'b1;
        err_adr = 32'hBFC0_0008;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (4) tick();
        checkOutput("s5_cyc_halt", 32'(ibus_cyc_o), 32'd0);
        checkOutput("s5_head0_err", 32'(id_err), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("s5_err_pc", id_pc, 32'hBFC0_0008);
        checkOutput("s5_err_flag", 32'(id_err), 32'd1);
        checkOutput("s5_err_inst", id_inst, 32'h0);
        base = ack_count;
        tick();
        tick();
        checkOutput("s5_halt_cyc", 32'(ibus_cyc_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h8000_0002);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("s5_jflush", 32'(id_valid), 32'd0);
        tick();
        checkOutput("s5_mis_valid", 32'(id_valid), 32'd1);
        checkOutput("s5_mis_pc", id_pc, 32'h8000_0002);
        checkOutput("s5_mis_err", 32'(id_err), 32'd1);
        checkOutput("s5_mis_cyc", 32'(ibus_cyc_o), 32'd0);
        tick();
        checkOutput("s5_mis_nobus", 32'(ibus_cyc_o), 32'd0);
        checkOutput("s5_acks0", 32'(ack_count - base), 32'd0);
        err_en = 1'b0;

        // Reset during WAIT; stray ack afterwards is ignored
        doReset();
        wait_n = 3;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("s6_stb", 32'(ibus_stb_o), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("s6_rst_cyc", 32'(ibus_cyc_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        checkOutput("s6_late_valid", 32'(id_valid), 32'd0);
        checkOutput("s6_restart_stb", 32'(ibus_stb_o), 32'd1);
        checkOutput("s6_restart_adr", ibus_adr_o, 32'hBFC0_0000);
        waitValid(10, "s6_wait_valid");
        checkOutput("s6_pc", id_pc, 32'hBFC0_0000);

        // fetch_pc wraps past the top of the address space
        wait_n = 0;
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("s7_valid", 32'(id_valid), 32'd0);
        tick();
        checkOutput("s7_adr_top", ibus_adr_o, 32'hFFFF_FFFC);
        tick();
        checkOutput("s7_adr_wrap", ibus_adr_o, 32'h0000_0000);
        checkOutput("s7_pc", id_pc, 32'hFFFF_FFFC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end replacing the single-cycle ibus fetch path. It owns the fetch PC, issues Wishbone classic requests to the instruction bus with arbitrary wait states, and buffers fetched words in a prefetch FIFO. ID consumes entries through a valid/ready handshake. Branch redirects flush the buffer and cancel in-flight fetches. Sits between the instruction bus and the IF/ID boundary.

Parameters:
ADDR_WIDTH, 32, PC and bus address width
DATA_WIDTH, 32, instruction word width
FIFO_DEPTH, 4, prefetch entries; power of two, >=2
RESET_PC, 32'hBFC00000, fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ibus_cyc_o  out  1  Wishbone cycle
ibus_stb_o  out  1  Wishbone strobe
ibus_adr_o  out  ADDR_WIDTH  fetch address
ibus_sel_o  out  DATA_WIDTH/8  byte select; constant all-ones
ibus_ack_i  in  1  transfer acknowledge
ibus_err_i  in  1  bus error terminates transfer
ibus_dat_i  in  DATA_WIDTH  read data
jump  in  1  redirect request from branch unit
jump_to  in  ADDR_WIDTH  redirect target
id_ready  in  1  ID accepts head entry
id_valid  out  1  head entry valid
id_pc  out  ADDR_WIDTH  head entry PC
id_inst  out  DATA_WIDTH  head entry instruction
id_err  out  1  head entry is a fetch fault (bus error or misaligned PC)

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). Reset: fetch_pc=RESET_PC, FIFO empty, state IDLE, cyc/stb=0, id_valid=0, id_pc/id_inst/id_err=0. Reset mid-transaction drops cyc/stb at the next edge; a late ack after reset is ignored (state IDLE).
- FSM states: IDLE, WAIT, DISCARD, HALT.
- IDLE: if FIFO count < FIFO_DEPTH and fetch_pc[1:0]==0 -> assert cyc/stb, adr=fetch_pc, go WAIT. If fetch_pc misaligned -> push {fetch_pc, 0, err=1} without bus access (if space), go HALT.
- WAIT: cyc/stb held, adr stable until ack or err.
  - ack: push {fetch_pc, ibus_dat_i, 0}; fetch_pc+=4. If post-update count < FIFO_DEPTH, stay WAIT with new adr next cycle (back-to-back, 1 word/cycle with zero-wait slave); else go IDLE, cyc/stb=0.
  - err: push {fetch_pc, 0, 1}; go HALT; cyc/stb=0.
- DISCARD: cyc/stb held until ack or err; response dropped; then IDLE.
- HALT: no requests until jump.
- jump (any state, highest priority over push/pop):
  - FIFO flushed at the edge; id_valid=0 next cycle; fetch_pc<=jump_to.
  - WAIT with no ack/err this cycle -> DISCARD; WAIT with ack/err this cycle -> response dropped, IDLE.
  - DISCARD stays DISCARD; IDLE/HALT -> IDLE.
- FIFO is first-word-fall-through: id_* show head combinationally from storage; pop when id_valid && id_ready. Push and pop in the same cycle leave count unchanged; push into full is impossible by construction (request issued only when a slot is free; assert in sim).
- Latency: ack sampled at edge N -> entry visible on id_* in cycle N+1. First stb in the first cycle after rst deasserts.
- fetch_pc wraps modulo 2^ADDR_WIDTH.

Decomposition:
- Package cpu_defs: FetchEntry_t {pc, inst, err}; FetchState_t enum {IDLE, WAIT, DISCARD, HALT}; default RESET_PC constant.
- Sub-module fetch_fifo: synchronous FWFT FIFO parametrised on depth and entry type, with push, pop, flush, count, empty and full outputs. Pointers are log2(FIFO_DEPTH)+1 bits to distinguish full from empty.

Test Plan:
- Zero-wait slave (ack same cycle as stb), id_ready=1 -> first stb cycle 1 after reset with adr=BFC00000; id_pc sequence BFC00000, BFC00004, ... one per cycle.
- id_ready=0, zero-wait slave -> exactly 4 entries fetched, then cyc=0; id_ready=1 for one cycle -> exactly one new request to BFC00010.
- Slave with 3 wait states; jump=1, jump_to=80001000 during wait cycle 1 -> stb held until ack; that data is not delivered; next adr=80001000; first id_pc=80001000.
- jump in the same cycle as ack, with FIFO holding 2 entries and id_ready=1 -> all dropped; next cycle id_valid=0; next request to jump_to.
- ibus_err_i on adr BFC00008 -> entry id_err=1 with id_pc=BFC00008; no further stb until jump; jump_to=80000002 -> no bus access, entry id_err=1 with id_pc=80000002.
- rst asserted during WAIT -> cyc/stb=0 next cycle; late ack ignored; first request after release to BFC00000.
